// File: rtl/dpram_port_master.sv
// rtl/dpram_port_master.sv - burst initiator for one port of the 64x8 dual-port RAM
// Drives registered addr/we/wdata and returns read beats through a credit-gated FIFO.
module dpram_port_master #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 8,
  parameter int BUF_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [ADDR_W-1:0] i_cmd_len,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_we,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_done_nxt;

  logic [ADDR_W-1:0] r_cur;
  logic [ADDR_W-1:0] r_rem;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_we;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_done;
  logic              r_issue_v;
  logic              r_ret_v;

  logic [DATA_W-1:0] r_buf [BUF_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_cmd_fire;
  logic              w_wr_beat;
  logic              w_issue;
  logic              w_last;
  logic              w_push;
  logic              w_pop;
  logic              w_drain_done;
  logic [CNT_W:0]    w_credit;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_cmd_fire = i_cmd_valid && (r_state == S_IDLE);
  assign w_wr_beat  = i_wr_valid && (r_state == S_WRITE);
  assign w_last     = (r_rem == '0);
  assign w_push     = r_ret_v;
  assign w_pop      = (r_count != '0) && i_rd_ready;

  // Beats already on the RAM pins or in q still need a buffer slot; a pop this cycle is not credited.
  assign w_credit = {1'b0, r_count} + (CNT_W + 1)'(r_issue_v) + (CNT_W + 1)'(r_ret_v);
  assign w_issue  = (r_state == S_READ) && (w_credit < (CNT_W + 1)'(BUF_DEPTH));

  // Finish in the cycle the final beat leaves, so done trails the last accept by one cycle.
  assign w_drain_done = (r_state == S_DRAIN) && !r_issue_v && !r_ret_v &&
                        ((r_count == '0) || ((r_count == CNT_W'(1)) && w_pop));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_fire) begin
          w_state_nxt = i_cmd_write ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (w_wr_beat && w_last) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      S_READ: begin
        if (w_issue && w_last) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_drain_done) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cur       <= '0;
      r_rem       <= '0;
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
      r_done      <= 1'b0;
      r_issue_v   <= 1'b0;
      r_ret_v     <= 1'b0;
    end else begin
      r_done    <= w_done_nxt;
      r_issue_v <= w_issue;
      r_ret_v   <= r_issue_v;
      r_ram_we  <= w_wr_beat;
      if (w_cmd_fire) begin
        r_cur <= i_cmd_addr;
        r_rem <= i_cmd_len;
      end else if (w_wr_beat || w_issue) begin
        r_ram_addr <= r_cur;
        r_cur      <= r_cur + ADDR_ONE;
        r_rem      <= r_rem - ADDR_ONE;
      end
      if (w_wr_beat) begin
        r_ram_wdata <= i_wr_data;
      end
    end
  end

  // Return buffer: q captured one cycle after the RAM registers it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_buf[r_wptr] <= i_ram_rdata;
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_wr_ready  = (r_state == S_WRITE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_rd_valid  = (r_count != '0);
  assign o_rd_data   = r_buf[r_rptr];
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_we    = r_ram_we;
  assign o_ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_dpram_port_master.sv
// tb/tb_dpram_port_master.sv - bench for dpram_port_master with a 64x8 synchronous RAM model
module tb_dpram_port_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [5:0] cmd_addr, cmd_len;
  logic [7:0] wr_data;
  logic       wr_valid, wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid, rd_ready;
  logic       busy, done;
  logic [5:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  dpram_port_master #(.ADDR_W(6), .DATA_W(8), .BUF_DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
    .i_wr_data(wr_data), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .i_rd_ready(rd_ready),
    .o_busy(busy), .o_done(done),
    .o_ram_addr(ram_addr), .o_ram_we(ram_we), .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata)
  );

  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 37 + 11) ^ 8'h5A);
  endfunction

  bit [7:0] mem   [64];
  bit       wflag [64];
  always @(posedge clk) begin
    ram_rdata <= wflag[ram_addr] ? mem[ram_addr] : init_val(int'(ram_addr));
    if (ram_we) begin
      mem[ram_addr]   <= ram_wdata;
      wflag[ram_addr] <= 1'b1;
    end
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [7:0]  exp_mem [64];
  logic [13:0] wq [$];
  logic [7:0]  rdq [$];
  int          we_cnt = 0, done_cnt = 0, done_cyc = 0;
  int          pops = 0, first_pop_cyc = 0, last_pop_cyc = 0, first_valid_cyc = -1;
  logic [7:0]  first_pop_data;
  bit          prev_stall = 0;
  logic [7:0]  prev_data;
  int          acc_cyc = 0, last_hs_cyc = 0, rd_done0 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    logic [13:0] ent;
    logic [7:0]  e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_stall = 0;
        continue;
      end
      chk("cmd_ready_eq_not_busy", cmd_ready, !busy);
      if (ram_we) begin
        we_cnt++;
        chk("ram_we_has_beat", int'(wq.size() > 0), 1);
        if (wq.size() > 0) begin
          ent = wq.pop_front();
          chk("ram_addr", ram_addr, ent[13:8]);
          chk("ram_wdata", ram_wdata, ent[7:0]);
        end
      end
      if (prev_stall) begin
        chk("rd_valid_held", rd_valid, 1);
        chk("rd_data_held", rd_data, prev_data);
      end
      if (rd_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (rd_valid && rd_ready) begin
        chk("rd_beat_expected", int'(rdq.size() > 0), 1);
        if (rdq.size() > 0) begin
          e = rdq.pop_front();
          chk("rd_data", rd_data, e);
        end
        if (pops == 0) begin
          first_pop_cyc  = cyc;
          first_pop_data = rd_data;
        end
        pops++;
        last_pop_cyc = cyc;
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input bit wr, input int addr, input int len);
    bit acc;
    acc       = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = 6'(addr);
    cmd_len   = 6'(len);
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      acc = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    chk("cmd_accepted", acc, 1);
    acc_cyc = cyc;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int t = 0; t < 300 && !idle; t++) begin
      @(negedge clk);
      idle = !busy;
    end
    chk("idle_reached", idle, 1);
    tick();
  endtask

  task automatic write_burst(input int addr, input int len, input logic [7:0] base, input bit gaps);
    int i, k, we0, d0;
    bit hs;
    i = 0; k = 0; we0 = we_cnt; d0 = done_cnt;
    send_cmd(1'b1, addr, len);
    while (i <= len && k < 100) begin
      wr_valid = gaps ? (k % 3 == 0) : 1'b1;
      wr_data  = base + 8'(i);
      @(negedge clk);
      hs = wr_valid && wr_ready;
      if (hs) begin
        wq.push_back({6'((addr + i) % 64), wr_data});
        exp_mem[(addr + i) % 64] = wr_data;
      end
      tick();
      if (hs) begin
        i++;
        last_hs_cyc = cyc;
      end
      k++;
    end
    wr_valid = 1'b0;
    chk("write_beats_accepted", i, len + 1);
    wait_idle();
    chk("write_ram_we_count", we_cnt - we0, len + 1);
    chk("write_done_pulses", done_cnt - d0, 1);
    chk("write_done_timing", done_cyc - last_hs_cyc, 1);
    chk("write_queue_drained", wq.size(), 0);
  endtask

  task automatic start_read(input int addr, input int len, input bit ready);
    for (int i = 0; i <= len; i++) rdq.push_back(exp_mem[(addr + i) % 64]);
    pops            = 0;
    first_valid_cyc = -1;
    rd_done0        = done_cnt;
    rd_ready        = ready;
    send_cmd(1'b0, addr, len);
  endtask

  task automatic finish_read(input int len);
    rd_ready = 1'b1;
    wait_idle();
    chk("read_beats", pops, len + 1);
    chk("read_queue_drained", rdq.size(), 0);
    chk("read_done_pulses", done_cnt - rd_done0, 1);
    chk("read_done_timing", done_cyc - last_pop_cyc, 1);
    chk("read_first_valid_latency", first_valid_cyc - acc_cyc, 4);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    wr_data = 0; wr_valid = 0; rd_ready = 0;
    for (int a = 0; a < 64; a++) exp_mem[a] = init_val(a);
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_cmd_ready", cmd_ready, 1);
    chk("rel_rd_data", rd_data, 0);
    chk("rel_ram_wdata", ram_wdata, 0);
    chk("rel_wr_ready", wr_ready, 0);
    tick();

    write_burst(10, 3, 8'hA0, 1'b0);
    chk("t1_last_ram_addr", ram_addr, 13);
    chk("t1_mem13", mem[13], 8'hA3);
    start_read(10, 3, 1'b1);
    finish_read(3);
    chk("t1_first_read", first_pop_data, 8'hA0);
    chk("t1_pop_span", last_pop_cyc - first_pop_cyc, 3);

    write_burst(62, 3, 8'hC0, 1'b0);
    chk("wrap_last_ram_addr", ram_addr, 1);
    chk("wrap_mem63", mem[63], 8'hC1);
    chk("wrap_mem0", mem[0], 8'hC2);
    start_read(62, 3, 1'b1);
    finish_read(3);
    chk("wrap_first_read", first_pop_data, 8'hC0);

    write_burst(20, 5, 8'h30, 1'b1);
    chk("gap_mem25", mem[25], 8'h35);
    start_read(20, 5, 1'b1);
    finish_read(5);

    start_read(0, 63, 1'b1);
    finish_read(63);
    chk("full_first_read", first_pop_data, 8'hC2);
    chk("full_back_to_back", last_pop_cyc - first_pop_cyc, 63);

    start_read(0, 7, 1'b0);
    for (int t = 0; t < 10; t++) begin
      if (t == 5) begin
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'd40; cmd_len = 6'd0;
        wr_valid = 1'b1; wr_data = 8'hEE;
      end
      @(negedge clk);
      if (t == 5) chk("busy_cmd_ready_low", cmd_ready, 0);
      tick();
      cmd_valid = 1'b0;
      wr_valid  = 1'b0;
    end
    @(negedge clk);
    chk("stall_last_issue_addr", ram_addr, 3);
    chk("stall_no_pops", pops, 0);
    chk("stall_rd_valid", rd_valid, 1);
    tick();
    finish_read(7);

    start_read(0, 63, 1'b1);
    repeat (8) tick();
    rst_n = 1'b0;
    rdq.delete();
    d0 = done_cnt;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_rd_valid", rd_valid, 0);
    chk("abort_rd_data", rd_data, 0);
    chk("abort_ram_addr", ram_addr, 0);
    chk("abort_ram_we", ram_we, 0);
    chk("abort_ram_wdata", ram_wdata, 0);
    chk("abort_done", done, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_idle", busy, 0);
    repeat (4) tick();
    chk("abort_no_done", done_cnt - d0, 0);

    start_read(10, 0, 1'b1);
    finish_read(0);
    chk("recover_read", first_pop_data, 8'hA0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
